ltc2308_spi_responder: RTL and testbench

- Synthesizable, cycle-accurate model of the LTC2308 ADC's serial interface: the device end of the CONVST/SCK/SDI/SDO link driven by the team's ADC controller.
- Used in simulation and for on-board loopback tests in place of the real chip.
- Returns 12-bit samples taken from a per-channel input bus, using the channel and polarity configuration latched in the previous frame (pipelined, as the real device does).

---
 rtl/ltc2308_spi_responder.sv | 176 +++++++++++++++++
 tb/tb_ltc2308_spi_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_spi_responder.sv
// Device end of the LTC2308 CONVST/SCK/SDI/SDO link; returns 12-bit samples from ch_data.
// Latency: pin events act SYNC_STAGES+1 cycles after the pin changes; busy is high for CONV_CYCLES cycles.
// Backpressure: none; the controller paces the frame through CONVST and SCK.
module ltc2308_spi_responder #(
    parameter int CONV_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [95:0] ch_data,
    input  logic        CONVST,
    input  logic        SCK,
    input  logic        SDI,
    output logic        SDO,
    output logic        busy,
    output logic [5:0]  config_q,
    output logic        frame_err
);

    localparam int CW = $clog2(CONV_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_WAIT, S_SHIFT, S_DONE} state_t;

    logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
    logic                   convst_d, sck_d;
    logic                   convst_s, sck_s, sdi_s;
    logic                   convst_rise, sck_rise, sck_fall;

    assign convst_s    = convst_sync[SYNC_STAGES-1];
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign convst_rise = convst_s & ~convst_d;
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            convst_sync <= '0;
            sck_sync    <= '0;
            sdi_sync    <= '0;
            convst_d    <= 1'b0;
            sck_d       <= 1'b0;
        end else begin
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], CONVST};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], SCK};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            convst_d    <= convst_s;
            sck_d       <= sck_s;
        end
    end

    // active_cfg holds {S/D,O/S,S1,S0,UNI}; SLP has no effect on the returned data
    state_t          state, state_n;
    logic            busy_n, sdo_n, ferr_n, start;
    logic [5:0]      cfgq_n, sdi_sr, sr_n;
    logic [4:0]      active_cfg, act_n;
    logic [11:0]     out_word, word_n;
    logic [CW-1:0]   cyc_cnt, cyc_n;
    logic [2:0]      rx_cnt, rx_n;
    logic [3:0]      tx_cnt, tx_n;
    logic [2:0]      sel_ch;
    logic [11:0]     sel_sample, sel_word;

    always_comb begin
        sel_ch = active_cfg[4] ? {active_cfg[2], active_cfg[1], active_cfg[3]}
                               : {active_cfg[2], active_cfg[1], 1'b0};
        sel_sample = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel_ch == 3'(i)) sel_sample = ch_data[i*12 +: 12];
        end
        sel_word = active_cfg[0] ? sel_sample : (sel_sample ^ 12'h800);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            SDO        <= 1'b0;
            frame_err  <= 1'b0;
            config_q   <= 6'b100010;
            active_cfg <= 5'b10001;
            out_word   <= '0;
            cyc_cnt    <= '0;
            rx_cnt     <= '0;
            tx_cnt     <= '0;
            sdi_sr     <= '0;
        end else begin
            state      <= state_n;
            busy       <= busy_n;
            SDO        <= sdo_n;
            frame_err  <= ferr_n;
            config_q   <= cfgq_n;
            active_cfg <= act_n;
            out_word   <= word_n;
            cyc_cnt    <= cyc_n;
            rx_cnt     <= rx_n;
            tx_cnt     <= tx_n;
            sdi_sr     <= sr_n;
        end
    end

    always_comb begin
        state_n = state;
        busy_n  = busy;
        sdo_n   = SDO;
        ferr_n  = 1'b0;
        cfgq_n  = config_q;
        act_n   = active_cfg;
        word_n  = out_word;
        cyc_n   = cyc_cnt;
        rx_n    = rx_cnt;
        tx_n    = tx_cnt;
        sr_n    = sdi_sr;
        start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (convst_rise) start = 1'b1;
            end
            S_CONV: begin
                if (cyc_cnt == '0) begin
                    busy_n  = 1'b0;
                    state_n = S_WAIT;
                end else begin
                    cyc_n = cyc_cnt - CW'(1);
                end
            end
            S_WAIT: begin
                if (convst_rise) begin
                    start  = 1'b1;
                    ferr_n = 1'b1;
                    sdo_n  = 1'b0;
                end else if (!convst_s) begin
                    state_n = S_SHIFT;
                    sdo_n   = out_word[11];
                    rx_n    = '0;
                    tx_n    = '0;
                    sr_n    = '0;
                end
            end
            S_SHIFT: begin
                if (convst_rise) begin
                    start  = 1'b1;
                    ferr_n = 1'b1;
                    sdo_n  = 1'b0;
                end else begin
                    if (sck_rise && rx_cnt < 3'd6) begin
                        sr_n = {sdi_sr[4:0], sdi_s};
                        rx_n = rx_cnt + 3'd1;
                    end
                    // zero-filled shift: after the 12th fall SDO naturally reads 0
                    if (sck_fall) begin
                        word_n = {out_word[10:0], 1'b0};
                        sdo_n  = out_word[10];
                        tx_n   = tx_cnt + 4'd1;
                        if (tx_cnt == 4'd11) state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (rx_cnt == 3'd6) begin
                    cfgq_n = sdi_sr;
                    act_n  = sdi_sr[5:1];
                end
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (start) begin
            state_n = S_CONV;
            busy_n  = 1'b1;
            word_n  = sel_word;
            cyc_n   = CW'(CONV_CYCLES - 1);
        end
    end

endmodule

// File: tb/tb_ltc2308_spi_responder.sv
// Bench for ltc2308_spi_responder: directed frames plus random frames, checked against a
// config-level reference model of channel selection, coding and one-frame config pipelining.
module tb_ltc2308_spi_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] ch_data = '0;
    logic        CONVST = 1'b0, SCK = 1'b0, SDI = 1'b0;
    logic        SDO, busy, frame_err;
    logic [5:0]  config_q;

    ltc2308_spi_responder #(.CONV_CYCLES(64), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .ch_data(ch_data),
        .CONVST(CONVST), .SCK(SCK), .SDI(SDI),
        .SDO(SDO), .busy(busy), .config_q(config_q), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0, fe_cnt = 0;
    logic [5:0] m_cfgq, m_act;

    always @(posedge clock) begin
        #1;
        if (frame_err) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference: pick the channel from the config fields, then apply offset coding arithmetically
    function automatic logic [11:0] model_word(input logic [5:0] cfg, input logic [95:0] d);
        int ch, s;
        ch = 4 * int'(cfg[3]) + 2 * int'(cfg[2]) + (cfg[5] ? int'(cfg[4]) : 0);
        s  = int'(d[ch*12 +: 12]);
        if (!cfg[1]) s = (s + 2048) % 4096;
        return 12'(s);
    endfunction

    task automatic do_reset();
        reset = 1'b1; CONVST = 1'b0; SCK = 1'b0; SDI = 1'b0;
        tick(3);
        reset  = 1'b0;
        m_cfgq = 6'b100010;
        m_act  = 6'b100010;
    endtask

    task automatic do_conv(input bit raise, output logic [11:0] exp_w);
        logic [95:0] saved;
        int n, cnt;
        exp_w = model_word(m_act, ch_data);
        saved = ch_data;
        if (raise) CONVST = 1'b1;
        n = 0;
        while (!busy && n < 20) begin tick(1); n++; end
        check_eq("busy_rise", busy, 1);
        check_eq("sdo_conv", SDO, 0);
        ch_data = {$urandom, $urandom, $urandom};
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (cnt == 5)  CONVST = 1'b0;
            if (cnt == 10) SCK = 1'b1;
            if (cnt == 14) SCK = 1'b0;
            tick(1);
        end
        CONVST = 1'b0; SCK = 1'b0;
        check_eq("busy_len", cnt, 64);
        ch_data = saved;
    endtask

    task automatic do_shift(input logic [5:0] cfg, input int nfalls, output logic [11:0] rd);
        rd = '0;
        tick(2);
        for (int i = 0; i < nfalls; i++) begin
            rd[11-i] = SDO;
            SDI = (i < 6) ? cfg[5-i] : 1'($urandom);
            tick(2); SCK = 1'b1; tick(4); SCK = 1'b0; tick(4);
        end
        SDI = 1'b0;
    endtask

    task automatic full_frame(input logic [5:0] cfg, input string tag, output logic [11:0] rd);
        logic [11:0] exp_w;
        int fe0;
        fe0 = fe_cnt;
        do_conv(1'b1, exp_w);
        do_shift(cfg, 12, rd);
        tick(4);
        check_eq({tag, "_data"}, rd, exp_w);
        check_eq({tag, "_sdo_idle"}, SDO, 0);
        m_cfgq = cfg;
        m_act  = cfg;
        check_eq({tag, "_cfg"}, config_q, m_cfgq);
        check_eq({tag, "_ferr"}, fe_cnt - fe0, 0);
    endtask

    initial begin
        logic [11:0] rd, exp_w;
        logic [5:0]  cfg;
        logic [2:0]  cc;
        int fe0;

        ch_data[11:0] = 12'h801;
        do_reset();
        check_eq("rst_sdo", SDO, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_cfg", config_q, 6'b100010);

        full_frame(6'b000000, "first", rd);
        check_eq("first_const", rd, 12'h801);

        ch_data[23:12] = 12'h123;
        full_frame(6'b110010, "pipe1", rd);
        check_eq("pipe1_const", rd, 12'h001);
        full_frame(6'b110010, "pipe2", rd);
        check_eq("pipe2_const", rd, 12'h123);

        full_frame(6'b100000, "bip0", rd);
        ch_data[11:0] = 12'h000;
        full_frame(6'b100000, "bip1", rd);
        check_eq("bip1_const", rd, 12'h800);
        ch_data[11:0] = 12'hFFF;
        full_frame(6'b100000, "bip2", rd);
        check_eq("bip2_const", rd, 12'h7FF);

        for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = 12'(n * 273);
        for (int c = 0; c < 9; c++) begin
            cc  = 3'(c);
            cfg = (c < 8) ? {1'b1, cc[0], cc[2], cc[1], 1'b1, 1'b0} : 6'b100010;
            full_frame(cfg, "sweep", rd);
            if (c > 0) check_eq("sweep_const", rd, 12'((c - 1) * 273));
        end

        ch_data[11:0] = 12'hABC;
        do_conv(1'b1, exp_w);
        do_shift(6'b011101, 5, rd);
        check_eq("abort_partial", rd[11:7], exp_w[11:7]);
        fe0 = fe_cnt;
        CONVST = 1'b1;
        do_conv(1'b0, exp_w);
        check_eq("abort_ferr", fe_cnt - fe0, 1);
        check_eq("abort_cfg", config_q, m_cfgq);
        check_eq("abort_word", exp_w, 12'hABC);
        do_shift(6'b110110, 12, rd);
        tick(4);
        check_eq("abort_next_data", rd, exp_w);
        m_cfgq = 6'b110110; m_act = 6'b110110;
        check_eq("abort_next_cfg", config_q, m_cfgq);
        full_frame(6'b100010, "abort_after", rd);

        do_conv(1'b1, exp_w);
        do_shift(6'b001101, 7, rd);
        reset = 1'b1;
        tick(1);
        check_eq("midrst_sdo", SDO, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_cfg", config_q, 6'b100010);
        reset  = 1'b0;
        m_cfgq = 6'b100010; m_act = 6'b100010;
        tick(2);
        full_frame(6'b100010, "post_rst", rd);
        check_eq("post_rst_const", rd, 12'hABC);

        for (int k = 0; k < 20; k++) begin
            ch_data = {$urandom, $urandom, $urandom};
            full_frame(6'($urandom), "rand", rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
